// File: rtl/icb_mem_responder_if.sv
// ICB command/response channel bundle shared by the memory responder and its masters.
// The master drives commands and rsp_ready; the slave drives cmd_ready and the response.
interface icb_mem_responder_if;
  logic [31:0] cmd_addr;
  logic        cmd_read;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_valid;
  logic        rsp_ready;

  modport master (
    output cmd_addr, cmd_read, cmd_wdata, cmd_wmask, cmd_valid,
    input  cmd_ready,
    input  rsp_rdata, rsp_err, rsp_valid,
    output rsp_ready
  );

  modport slave (
    input  cmd_addr, cmd_read, cmd_wdata, cmd_wmask, cmd_valid,
    output cmd_ready,
    output rsp_rdata, rsp_err, rsp_valid,
    input  rsp_ready
  );
endinterface

// File: rtl/icb_mem_responder.sv
// ICB slave in front of a single-port SRAM with 1-cycle read latency. Responses are returned
// in command order through a bypassable pend stage and a small response FIFO.
module icb_mem_responder #(
  parameter int unsigned MEM_DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int unsigned RSP_BUF_DEPTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  icb_mem_responder_if.slave   s_icb,
  output logic                 o_bram_en,
  output logic [3:0]           o_bram_wen,
  output logic [29:0]          o_bram_addr,
  output logic [31:0]          o_bram_din,
  input  logic [31:0]          i_bram_dout
);

  localparam int unsigned CNT_W     = $clog2(RSP_BUF_DEPTH + 1);
  localparam int unsigned PTR_W     = (RSP_BUF_DEPTH > 1) ? $clog2(RSP_BUF_DEPTH) : 1;
  localparam logic [32:0] WIN_BYTES = 33'(MEM_DEPTH) * 33'd4;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(RSP_BUF_DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  logic             r_active;
  logic             r_pend_vld;
  logic             r_pend_read;
  logic             r_pend_err;
  rsp_t             r_buf [RSP_BUF_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_buf_cnt;

  logic [31:0]      w_offset;
  logic             w_err;
  logic [CNT_W:0]   w_used;
  logic             w_cmd_ready;
  logic             w_fire;
  rsp_t             w_pend_rsp;
  rsp_t             w_rsp;
  logic             w_buf_nonempty;
  logic             w_rsp_valid;
  logic             w_pop_buf;
  logic             w_push;

  // Command decode: window offset, error detection and credit-based ready.
  always_comb begin
    w_offset    = s_icb.cmd_addr - BASE_ADDR;
    w_err       = (s_icb.cmd_addr[1:0] != 2'b00) | ({1'b0, w_offset} >= WIN_BYTES);
    w_used      = {1'b0, r_buf_cnt} + {{CNT_W{1'b0}}, r_pend_vld};
    w_cmd_ready = r_active & (w_used < (CNT_W + 1)'(RSP_BUF_DEPTH));
    w_fire      = s_icb.cmd_valid & w_cmd_ready;
  end

  // SRAM port is driven in the fire cycle itself; erroneous commands never touch memory.
  always_comb begin
    o_bram_en   = w_fire & ~w_err;
    o_bram_addr = w_offset[31:2];
    o_bram_din  = s_icb.cmd_wdata;
    if (w_fire && !w_err && !s_icb.cmd_read) begin
      o_bram_wen = s_icb.cmd_wmask;
    end else begin
      o_bram_wen = 4'b0000;
    end
  end

  // Response selection: FIFO head when anything is buffered, otherwise bypass from pend.
  always_comb begin
    w_pend_rsp.err = r_pend_vld & r_pend_err;
    if (r_pend_vld && r_pend_read && !r_pend_err) begin
      w_pend_rsp.rdata = i_bram_dout;
    end else begin
      w_pend_rsp.rdata = 32'h0000_0000;
    end
    w_buf_nonempty = (r_buf_cnt != {CNT_W{1'b0}});
    w_rsp_valid    = w_buf_nonempty | r_pend_vld;
    if (w_buf_nonempty) begin
      w_rsp = r_buf[r_rd_ptr];
    end else begin
      w_rsp = w_pend_rsp;
    end
    w_pop_buf = w_rsp_valid & s_icb.rsp_ready & w_buf_nonempty;
    // Pend must be captured now: bram_dout is only guaranteed for this one cycle.
    w_push    = r_pend_vld & (w_buf_nonempty | ~s_icb.rsp_ready);
  end

  assign s_icb.cmd_ready = w_cmd_ready;
  assign s_icb.rsp_valid = w_rsp_valid;
  assign s_icb.rsp_rdata = w_rsp.rdata;
  assign s_icb.rsp_err   = w_rsp.err;

  // Ready gate: no commands accepted until the first cycle after reset is released.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_active <= 1'b0;
    end else begin
      r_active <= 1'b1;
    end
  end

  // Pend stage: tracks the command issued to the SRAM in the previous cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend_vld  <= 1'b0;
      r_pend_read <= 1'b0;
      r_pend_err  <= 1'b0;
    end else begin
      r_pend_vld  <= w_fire;
      r_pend_read <= w_fire & s_icb.cmd_read;
      r_pend_err  <= w_fire & w_err;
    end
  end

  // Response FIFO bookkeeping; reset discards everything outstanding.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr  <= {PTR_W{1'b0}};
      r_rd_ptr  <= {PTR_W{1'b0}};
      r_buf_cnt <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop_buf) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_buf_cnt <= r_buf_cnt + {{(CNT_W - 1){1'b0}}, w_push} - {{(CNT_W - 1){1'b0}}, w_pop_buf};
    end
  end

  // Response FIFO storage.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_buf[r_wr_ptr] <= w_pend_rsp;
    end
  end

endmodule
